mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory between two bus masters: m0 (core load/store/fetch port) and m1 (DMA/debug port).
- Each master issues single-beat transactions over a valid/ready handshake. The arbiter picks a winner by 2-way round-robin, drives the memory strobes and returns read data to the owner.
- Sits between the core/DMA and the memory macro. Only one transaction is in flight at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- RD_LAT, 1, cycles from the mem_re cycle to valid mem_rdata; legal range 1..7

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  request valid; held with its fields until the handshake
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_be / m1_be  in  DATA_W/8  byte enables
- m0_gnt / m1_gnt  out  1  ready; handshake occurs on the edge where req and gnt are both high
- m0_rvalid / m1_rvalid  out  1  one-cycle read-response pulse
- m0_rdata / m1_rdata  out  DATA_W  read data, valid while rvalid is high; held afterwards
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (asynchronous, active-low): state IDLE, rr_last=1 (so m0 wins the first tie), all outputs 0, captured request cleared.
- Reset mid-transaction: the transaction is dropped, no rvalid is produced and strobes drop immediately.
- FSM states:
  - IDLE
    - gnt is combinational: high only in IDLE, and only for the winner.
    - Winner: the sole requester; if both request, the master not equal to rr_last.
    - On the handshake edge: latch we/addr/wdata/be into mem_*, set rr_last=winner, go to ISSUE.
  - ISSUE (1 cycle)
    - mem_we or mem_re high for exactly this cycle; mem_addr/mem_be/mem_wdata valid.
    - Write: next state IDLE.
    - Read: next state WAIT, counter loaded with RD_LAT-1.
  - WAIT (RD_LAT cycles, decrementing counter)
    - On the edge ending the final WAIT cycle, capture mem_rdata into the owner's rdata register.
    - Next state RESP.
  - RESP (1 cycle)
    - Owner's rvalid=1; next state IDLE.
- Latency:
  - Write: handshake to mem_we is 1 cycle. Back-to-back writes sustain 1 transaction per 2 cycles.
  - Read: rvalid occurs RD_LAT+1 cycles after the mem_re cycle.
- Masters must not re-present req in the cycle after their handshake unless they intend a new transaction. It is sampled only in IDLE.
- Only one rvalid is high in any cycle. gnt is never high outside IDLE. Both gnts are never high together.
- mem_addr/mem_wdata/mem_be hold their last value outside ISSUE; strobes are 0 outside ISSUE.
- A req that drops before its handshake is never granted; this is legal.

Optional Feature:
- Macro: MEM_ARB_PERF_EN
- Defined:
  - Adds input perf_clr (1) and outputs perf_gnt0 and perf_gnt1 (32 each).
  - Each counter increments on its master's handshake edge and wraps at 2^32.
  - perf_clr zeroes both counters synchronously, with priority over increment.
  - Counters reset to 0.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - constants MASTER_CORE=0 and MASTER_DMA=1
  - RD_LAT legal-range bounds
- One sub-module, mem_arb_rr: combinational 2-way round-robin picker.
  - Inputs: req[1:0], rr_last.
  - Outputs: winner, any.

Test Plan:
- Single write: m0 writes addr 0x100, wdata 0xDEADBEEF, be 4'b1111 -> m0_gnt high in IDLE; mem_we high exactly 1 cycle with those values; back to IDLE the following cycle.
- Contention: m0 and m1 both hold read requests continuously after reset -> grants alternate m0, m1, m0, m1. Each rvalid goes to the correct master with the data the memory model returned.
- Latency: RD_LAT=3, m1 reads 0x40 (model returns 0x12345678) -> m1_rvalid 4 cycles after the mem_re cycle, m1_rdata=0x12345678, no m0_rvalid.
- Reset mid-op: assert rst_n=0 during WAIT -> all outputs 0 immediately, no rvalid afterwards. A subsequent m1-only request is granted; m0 wins the next tie.
- Starvation: m0 requests back-to-back while m1 waits -> m1 is granted at the next IDLE after m0's current transaction.
- Perf (MEM_ARB_PERF_EN): 5 m0 and 3 m1 handshakes -> perf_gnt0=5, perf_gnt1=3. perf_clr pulse -> both 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Holds the arbiter FSM state encoding, master ids and read-latency bounds.
// Imported by mem_arb_rr and mem_bus_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic MASTER_CORE = 1'b0;
  localparam logic MASTER_DMA  = 1'b1;

  // Legal range of the RD_LAT parameter; the wait counter is sized for the max.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  localparam int LAT_CNT_W  = 3;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the master
// that did not win last time. Purely combinational, zero latency.
// No backpressure of its own; the caller decides when the pick is consumed.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       winner,
  output logic       any
);

  // Pick the winner from the request pair and the last-granted master.
  always_comb begin
    winner = MASTER_CORE;
    any    = |req;
    case (req)
      2'b10:   winner = MASTER_DMA;
      2'b11:   winner = ~rr_last;
      default: winner = MASTER_CORE;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between core (m0) and DMA (m1), one transaction in flight.
// Latency: write handshake->mem_we 1 cycle; read mem_re->rvalid RD_LAT+1 cycles.
// Backpressure: gnt only in IDLE for the round-robin winner. MEM_ARB_PERF_EN adds grant counters.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1      // 1..7 (RD_LAT_MIN..RD_LAT_MAX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_be,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_be,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [31:0]           perf_gnt0,
  output logic [31:0]           perf_gnt1
`endif
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

  state_t               state, state_nxt;
  logic [LAT_CNT_W-1:0] cnt, cnt_nxt;
  logic                 rr_last;
  logic                 owner;
  logic                 we_q;
  logic                 winner;
  logic                 any;
  logic                 hs;
  logic                 last_wait;

  mem_arb_rr u_rr (
    .req     ({m1_req, m0_req}),
    .rr_last (rr_last),
    .winner  (winner),
    .any     (any)
  );

  // A handshake always happens in IDLE when anyone requests: the winner is a requester.
  assign hs        = (state == IDLE) && any;
  assign last_wait = (state == WAIT) && (cnt == '0);

  assign m0_gnt    = hs && (winner == MASTER_CORE);
  assign m1_gnt    = hs && (winner == MASTER_DMA);
  assign mem_we    = (state == ISSUE) &&  we_q;
  assign mem_re    = (state == ISSUE) && !we_q;
  assign m0_rvalid = (state == RESP) && (owner == MASTER_CORE);
  assign m1_rvalid = (state == RESP) && (owner == MASTER_DMA);

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (hs) state_nxt = ISSUE;
      ISSUE: begin
        if (we_q) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the winning request; rr_last starts at DMA so the core wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last   <= MASTER_DMA;
      owner     <= MASTER_CORE;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (hs) begin
      rr_last   <= winner;
      owner     <= winner;
      we_q      <= winner ? m1_we    : m0_we;
      mem_addr  <= winner ? m1_addr  : m0_addr;
      mem_wdata <= winner ? m1_wdata : m0_wdata;
      mem_be    <= winner ? m1_be    : m0_be;
    end
  end

  // Read data lands in the owner's register at the end of the last WAIT cycle and is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (last_wait) begin
      if (owner == MASTER_DMA) m1_rdata <= mem_rdata;
      else                     m0_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Per-master handshake counters; clear wins over increment, wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_gnt0 <= '0;
      perf_gnt1 <= '0;
    end else if (perf_clr) begin
      perf_gnt0 <= '0;
      perf_gnt1 <= '0;
    end else begin
      if (m0_req && m0_gnt) perf_gnt0 <= perf_gnt0 + 32'd1;
      if (m1_req && m1_gnt) perf_gnt1 <= perf_gnt1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with RD_LAT=3 and a pipelined memory model.
// Stimulus pushes expected grants, memory strobes and read data; a negedge monitor pops and compares.
// Define MEM_ARB_PERF_EN to also exercise the grant counters.
module tb_mem_bus_arbiter;

  localparam int LAT = 3;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_we, mem_re;
`ifdef MEM_ARB_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_gnt0, perf_gnt1;
`endif

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int last_hs = 0;

  int          exp_gnt [$];
  mem_t        exp_mem [$];
  logic [31:0] exp_rd0 [$];
  logic [31:0] exp_rd1 [$];
  int          re_cyc  [$];
  int          hs_log  [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (req[0]),
    .m0_we     (we[0]),
    .m0_addr   (addr[0]),
    .m0_wdata  (wdata[0]),
    .m0_be     (be[0]),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (req[1]),
    .m1_we     (we[1]),
    .m1_addr   (addr[1]),
    .m1_wdata  (wdata[1]),
    .m1_be     (be[1]),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_clr  (perf_clr),
    .perf_gnt0 (perf_gnt0),
    .perf_gnt1 (perf_gnt1)
`endif
  );

  // Memory model: data for an address read in cycle T is presented in cycle T+LAT.
  logic [LAT-1:0] pipe_v = '0;
  logic [31:0]    pipe_a [LAT];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h40) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
  endfunction

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], mem_re};
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end

  assign mem_rdata = pipe_v[LAT-1] ? mem_f(pipe_a[LAT-1]) : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event happened with nothing expected", name);
  endtask

  function automatic logic gnt_of(input int m);
    return (m == 1) ? m1_gnt : m0_gnt;
  endfunction

  task automatic expect_txn(input int m, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b);
    mem_t e;
    e.we = w; e.a = a; e.d = d; e.b = b;
    exp_gnt.push_back(m);
    exp_mem.push_back(e);
  endtask

  // Present one transaction, wait (bounded) for the handshake edge, then release req.
  task automatic drive(input int m, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    bit got = 0;
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d; be[m] = b;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (gnt_of(m)) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req[m] = 1'b0;
    if (!got) begin
      checks++;
      $display("FAIL grant_timeout: master %0d got no gnt expected gnt within 60 cycles", m);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, mem_re, mem_be}, 64'd0);
    check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    check({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'd0);
  endtask

  // Monitor: protocol invariants, grant order, memory strobes, read responses and latency.
  bit          prev_strobe = 0;
  int          mon_m;
  mem_t        mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_strobe = 0;
      end else begin
        check("invariants",
              {m0_gnt & m1_gnt, m0_rvalid & m1_rvalid, (m0_gnt | m1_gnt) & (mem_we | mem_re),
               mem_we & mem_re, prev_strobe & (mem_we | mem_re)}, 64'd0);
        prev_strobe = mem_we | mem_re;
        if ((req[0] && m0_gnt) || (req[1] && m1_gnt)) begin
          mon_m = m1_gnt ? 1 : 0;
          if (exp_gnt.size() == 0) fail_now("grant_unexpected");
          else check("grant_order", mon_m, exp_gnt.pop_front());
          last_hs = cyc;
          hs_log.push_back(cyc);
        end
        if (mem_we || mem_re) begin
          check("hs_to_strobe", cyc, last_hs + 1);
          if (exp_mem.size() == 0) fail_now("strobe_unexpected");
          else begin
            mon_e = exp_mem.pop_front();
            check("mem_we", mem_we, mon_e.we);
            check("mem_addr", mem_addr, mon_e.a);
            check("mem_wdata", mem_wdata, mon_e.d);
            check("mem_be", mem_be, mon_e.b);
          end
          if (mem_re) re_cyc.push_back(cyc);
        end
        if (m0_rvalid) begin
          if (exp_rd0.size() == 0) fail_now("m0_rvalid_unexpected");
          else check("m0_rdata", m0_rdata, exp_rd0.pop_front());
          if (re_cyc.size() == 0) fail_now("m0_rvalid_orphan");
          else check("rd_latency", cyc - re_cyc.pop_front(), LAT + 1);
        end
        if (m1_rvalid) begin
          if (exp_rd1.size() == 0) fail_now("m1_rvalid_unexpected");
          else check("m1_rdata", m1_rdata, exp_rd1.pop_front());
          if (re_cyc.size() == 0) fail_now("m1_rvalid_orphan");
          else check("rd_latency", cyc - re_cyc.pop_front(), LAT + 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected $finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
    end
`ifdef MEM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Contention: both hold reads; grants alternate m0, m1, m0, m1.
    expect_txn(0, 1'b0, 32'h200, 32'h0, 4'hF);
    expect_txn(1, 1'b0, 32'h300, 32'h0, 4'hF);
    expect_txn(0, 1'b0, 32'h204, 32'h0, 4'hF);
    expect_txn(1, 1'b0, 32'h304, 32'h0, 4'hF);
    exp_rd0.push_back(32'hA5A5_0200);
    exp_rd0.push_back(32'hA5A5_0204);
    exp_rd1.push_back(32'hA5A5_0300);
    exp_rd1.push_back(32'hA5A5_0304);
    fork
      begin
        drive(0, 1'b0, 32'h200, 32'h0, 4'hF);
        drive(0, 1'b0, 32'h204, 32'h0, 4'hF);
      end
      begin
        drive(1, 1'b0, 32'h300, 32'h0, 4'hF);
        drive(1, 1'b0, 32'h304, 32'h0, 4'hF);
      end
    join
    idle(8);

    // Single and back-to-back writes from m0: one transaction every 2 cycles.
    hs_log.delete();
    expect_txn(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111);
    expect_txn(0, 1'b1, 32'h104, 32'h0BAD_F00D, 4'b0011);
    drive(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111);
    drive(0, 1'b1, 32'h104, 32'h0BAD_F00D, 4'b0011);
    idle(4);
    if (hs_log.size() != 2) fail_now("b2b_write_handshakes");
    else check("b2b_write_spacing", hs_log[1] - hs_log[0], 2);

    // Latency: m1 reads 0x40, response LAT+1 cycles after mem_re, no m0_rvalid.
    expect_txn(1, 1'b0, 32'h40, 32'h0, 4'hF);
    exp_rd1.push_back(32'h1234_5678);
    drive(1, 1'b0, 32'h40, 32'h0, 4'hF);
    idle(8);
    check("m1_rdata_held", m1_rdata, 32'h1234_5678);

    // Starvation: m0 streams writes, m1 arrives mid-transaction and wins the next IDLE.
    expect_txn(0, 1'b1, 32'h500, 32'h1111_1111, 4'hF);
    expect_txn(1, 1'b1, 32'h600, 32'h4444_4444, 4'hC);
    expect_txn(0, 1'b1, 32'h504, 32'h2222_2222, 4'h1);
    expect_txn(0, 1'b1, 32'h508, 32'h3333_3333, 4'h8);
    fork
      begin
        drive(0, 1'b1, 32'h500, 32'h1111_1111, 4'hF);
        drive(0, 1'b1, 32'h504, 32'h2222_2222, 4'h1);
        drive(0, 1'b1, 32'h508, 32'h3333_3333, 4'h8);
      end
      begin
        @(posedge clk);
        #1;
        drive(1, 1'b1, 32'h600, 32'h4444_4444, 4'hC);
      end
    join
    idle(4);

    // Reset during WAIT: everything drops, the read never responds.
    expect_txn(0, 1'b0, 32'h700, 32'h0, 4'hF);
    drive(0, 1'b0, 32'h700, 32'h0, 4'hF);
    idle(1);
    rst_n = 1'b0;
    #1 check_zero("midop_reset");
    re_cyc.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);

    // After reset m0 wins the tie again, then an m1-only request is granted.
    expect_txn(0, 1'b1, 32'h900, 32'h9999_9999, 4'hF);
    expect_txn(1, 1'b1, 32'hA00, 32'hAAAA_AAAA, 4'hF);
    fork
      drive(0, 1'b1, 32'h900, 32'h9999_9999, 4'hF);
      drive(1, 1'b1, 32'hA00, 32'hAAAA_AAAA, 4'hF);
    join
    expect_txn(1, 1'b1, 32'h800, 32'h8888_8888, 4'hF);
    drive(1, 1'b1, 32'h800, 32'h8888_8888, 4'hF);
    idle(4);

`ifdef MEM_ARB_PERF_EN
    check("perf_after_reset", {perf_gnt0, perf_gnt1}, {32'd1, 32'd2});
    perf_clr = 1'b1;
    idle(1);
    perf_clr = 1'b0;
    check("perf_clr", {perf_gnt0, perf_gnt1}, 64'd0);
    for (int i = 0; i < 5; i++) expect_txn(0, 1'b1, 32'hB00 + 32'(4 * i), 32'(i), 4'hF);
    for (int i = 0; i < 3; i++) expect_txn(1, 1'b1, 32'hC00 + 32'(4 * i), 32'(i), 4'hF);
    for (int i = 0; i < 5; i++) drive(0, 1'b1, 32'hB00 + 32'(4 * i), 32'(i), 4'hF);
    for (int i = 0; i < 3; i++) drive(1, 1'b1, 32'hC00 + 32'(4 * i), 32'(i), 4'hF);
    idle(4);
    check("perf_counts", {perf_gnt0, perf_gnt1}, {32'd5, 32'd3});
`endif

    idle(10);
    check("leftover_expectations",
          {16'(exp_gnt.size()), 16'(exp_mem.size()), 16'(exp_rd0.size()), 16'(exp_rd1.size())},
          64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
